// File: rtl/div_share_arbiter_pkg.sv
// Shared types and helpers for the divider-sharing arbiter and its sequential divider.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int MAX_WIDTH = 32;
    localparam logic [MAX_WIDTH-1:0] DBZ_QUOT = '1;

    function automatic int div_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_share_arbiter_if.sv
// Request/response bundle between arithmetic clients (master) and the divider arbiter (slave).
interface div_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = div_pkg::div_clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_dividend;
    logic [NREQ*WIDTH-1:0] req_divisor;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_quotient;
    logic [WIDTH-1:0]      rsp_remainder;
    logic                  rsp_dbz;
    logic                  busy;

    modport master (
        output req_valid, req_dividend, req_divisor, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, busy
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, busy
    );
endinterface

// File: rtl/div_share_arbiter_div.sv
// Sequential restoring divider, one shift/subtract/restore step per cycle.
// Latency: done pulses WIDTH cycles after start; no backpressure, a new start restarts it.
module restoring_div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = div_clog2(WIDTH + 1);

    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dsr_q, dsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step_rem, step_quo, step_dsr;
    logic [WIDTH:0]   shifted, diff;

    // The start cycle already performs the first step so done lands exactly WIDTH cycles later.
    always_comb begin
        step_rem = start ? '0       : rem_q;
        step_quo = start ? dividend : quo_q;
        step_dsr = start ? divisor  : dsr_q;
        shifted  = {step_rem, step_quo[WIDTH-1]};
        diff     = shifted - {1'b0, step_dsr};
        quo_d    = quo_q;
        rem_d    = rem_q;
        dsr_d    = dsr_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        if (start || cnt_q != '0) begin
            dsr_d    = step_dsr;
            quo_d    = step_quo << 1;
            quo_d[0] = ~diff[WIDTH];
            rem_d    = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            if (start) begin
                cnt_d  = CW'(WIDTH - 1);
                done_d = (WIDTH == 1);
            end else begin
                cnt_d  = cnt_q - CW'(1);
                done_d = (cnt_q == CW'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: rtl/div_share_arbiter.sv
// Round-robin share of one restoring divider among NREQ clients; divide-by-zero bypasses the divider.
// Latency: WIDTH+2 cycles accept->rsp (2 for dbz); rsp_ready low holds the response and blocks all accepts.
module div_share_arbiter
    import div_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = div_clog2(NREQ)
) (
    input logic                clk,
    input logic                reset_n,
    div_share_arbiter_if.slave bus
);
    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d, id_q, id_d;
    logic [WIDTH-1:0] dividend_q, dividend_d, divisor_q, divisor_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic             dbz_q, dbz_d, rsp_valid_q, rsp_valid_d, busy_q, busy_d;

    logic [IDW-1:0]   grant, idx;
    logic [IDW:0]     sum;
    logic             grant_vld;
    logic             div_start, div_done;
    logic [WIDTH-1:0] div_quotient, div_remainder;

    // Scan downwards so the first valid index at or after rr_ptr wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_q} + (IDW + 1)'(k);
            if (sum >= (IDW + 1)'(NREQ)) sum = sum - (IDW + 1)'(NREQ);
            idx = sum[IDW-1:0];
            if (bus.req_valid[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (reset_n && state_q == ST_IDLE && grant_vld) bus.req_ready[grant] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        div_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    id_d       = grant;
                    dividend_d = WIDTH'(bus.req_dividend >> (grant * WIDTH));
                    divisor_d  = WIDTH'(bus.req_divisor >> (grant * WIDTH));
                    rr_ptr_d   = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (divisor_q == '0) begin
                    quot_d  = DBZ_QUOT[WIDTH-1:0];
                    rem_d   = dividend_q;
                    dbz_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    div_start = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (div_done) begin
                    quot_d  = div_quotient;
                    rem_d   = div_remainder;
                    dbz_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            dbz_q       <= dbz_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    restoring_div_seq #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (dividend_q),
        .divisor   (divisor_q),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = id_q;
    assign bus.rsp_quotient  = quot_q;
    assign bus.rsp_remainder = rem_q;
    assign bus.rsp_dbz       = dbz_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed and swept checks of div_share_arbiter against a queue-based behavioural model.
module tb_div_share_arbiter;
    localparam int NREQ     = 4;
    localparam int WIDTH    = 4;
    localparam int IDW      = 2;
    localparam int NORM_LAT = WIDTH + 2;
    localparam int DBZ_LAT  = 2;

    typedef struct {
        int id;
        int q;
        int r;
        int dbz;
        int acc;
        bit seen;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    exp_t exp_q[$];
    int grant_log[$];
    int acc_cnt[NREQ];
    int model_rr = 0;
    int acc_total = 0;
    int rsp_total = 0;
    int start_cnt = 0;
    int last_id, last_q, last_r, last_dbz, last_lat;
    int m_exp_ready, m_found, m_valid, m_ready, m_g, m_a, m_b;

    div_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    div_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Model: one op outstanding at a time, grant = first valid at/after the pointer, plain / and %.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_req_ready", int'(bus.req_ready), 0);
            chk("rst_rsp_id", int'(bus.rsp_id), 0);
            chk("rst_rsp_quotient", int'(bus.rsp_quotient), 0);
            chk("rst_rsp_remainder", int'(bus.rsp_remainder), 0);
            chk("rst_rsp_dbz", int'(bus.rsp_dbz), 0);
            exp_q.delete();
            model_rr = 0;
        end else begin
            m_valid = int'(bus.req_valid);
            m_ready = int'(bus.req_ready);
            chk("busy", int'(bus.busy), (exp_q.size() != 0) ? 1 : 0);
            m_exp_ready = 0;
            m_found = 0;
            if (exp_q.size() == 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_found == 0 && ((m_valid >> ((model_rr + k) % NREQ)) & 1) != 0) begin
                        m_found = 1;
                        m_exp_ready = 1 << ((model_rr + k) % NREQ);
                    end
                end
            end
            chk("req_ready", m_ready, m_exp_ready);
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    chk("rsp_id", int'(bus.rsp_id), exp_q[0].id);
                    chk("rsp_quotient", int'(bus.rsp_quotient), exp_q[0].q);
                    chk("rsp_remainder", int'(bus.rsp_remainder), exp_q[0].r);
                    chk("rsp_dbz", int'(bus.rsp_dbz), exp_q[0].dbz);
                    if (!exp_q[0].seen) begin
                        exp_q[0].seen = 1'b1;
                        last_lat = cyc - exp_q[0].acc;
                        chk("rsp_latency", last_lat, (exp_q[0].dbz != 0) ? DBZ_LAT : NORM_LAT);
                        last_id  = int'(bus.rsp_id);
                        last_q   = int'(bus.rsp_quotient);
                        last_r   = int'(bus.rsp_remainder);
                        last_dbz = int'(bus.rsp_dbz);
                    end
                    if (bus.rsp_ready) begin
                        void'(exp_q.pop_front());
                        rsp_total++;
                    end
                end
            end
            if ((m_valid & m_ready) != 0) begin
                m_g = 0;
                for (int k = 0; k < NREQ; k++) if (((m_valid & m_ready) >> k) & 1) m_g = k;
                m_a = (int'(bus.req_dividend) >> (m_g * WIDTH)) & 15;
                m_b = (int'(bus.req_divisor) >> (m_g * WIDTH)) & 15;
                if (m_b == 0) exp_q.push_back('{m_g, 15, m_a, 1, cyc, 1'b0});
                else          exp_q.push_back('{m_g, m_a / m_b, m_a % m_b, 0, cyc, 1'b0});
                model_rr = (m_g + 1) % NREQ;
                acc_cnt[m_g]++;
                acc_total++;
                grant_log.push_back(m_g);
            end
            if (dut.div_start) start_cnt++;
        end
    end

    task automatic tick(input bit rnd);
        @(posedge clk);
        #1;
        if (rnd) bus.rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic set_ops(input int id, input int a, input int b);
        bus.req_dividend = (bus.req_dividend & ~(16'hF << (id * WIDTH))) | (16'(a & 15) << (id * WIDTH));
        bus.req_divisor  = (bus.req_divisor  & ~(16'hF << (id * WIDTH))) | (16'(b & 15) << (id * WIDTH));
    endtask

    task automatic send(input int id, input int a, input int b, input bit rnd);
        int c0;
        int t;
        set_ops(id, a, b);
        bus.req_valid = bus.req_valid | 4'(1 << id);
        c0 = acc_cnt[id];
        t = 0;
        while (acc_cnt[id] == c0 && t < 300) begin
            tick(rnd);
            t++;
        end
        if (acc_cnt[id] == c0) chk("accept_timeout", 0, 1);
        bus.req_valid = bus.req_valid & ~4'(1 << id);
    endtask

    task automatic wait_rsp(input int target, input bit rnd);
        int t;
        t = 0;
        while (rsp_total < target && t < 600) begin
            tick(rnd);
            t++;
        end
        if (rsp_total < target) chk("rsp_timeout", rsp_total, target);
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        reset_n = 1'b0;
        repeat (3) tick(1'b0);
        reset_n = 1'b1;
        tick(1'b0);
    endtask

    initial begin
        int r0, s0, g0, a0, t, c3;
        int order[5];
        order = '{0, 1, 2, 3, 0};
        bus.req_valid    = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.rsp_ready    = 1'b0;
        do_reset();

        // 1: lone 13/3
        bus.rsp_ready = 1'b1;
        r0 = rsp_total;
        send(0, 13, 3, 1'b0);
        wait_rsp(r0 + 1, 1'b0);
        chk("t1_id", last_id, 0);
        chk("t1_quotient", last_q, 4);
        chk("t1_remainder", last_r, 1);
        chk("t1_dbz", last_dbz, 0);
        chk("t1_latency", last_lat, 6);

        // 2: divide by zero bypasses the divider
        r0 = rsp_total;
        s0 = start_cnt;
        send(2, 7, 0, 1'b0);
        wait_rsp(r0 + 1, 1'b0);
        chk("t2_id", last_id, 2);
        chk("t2_quotient", last_q, 15);
        chk("t2_remainder", last_r, 7);
        chk("t2_dbz", last_dbz, 1);
        chk("t2_latency", last_lat, 2);
        chk("t2_div_start_pulses", start_cnt - s0, 0);

        // 3: all four valid continuously
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, 15, 15);
        g0 = grant_log.size();
        r0 = rsp_total;
        bus.req_valid = '1;
        t = 0;
        while (grant_log.size() < g0 + 5 && t < 300) begin
            tick(1'b0);
            t++;
        end
        bus.req_valid = '0;
        chk("t3_accepts", grant_log.size() - g0, 5);
        for (int i = 0; i < 5; i++) begin
            if (g0 + i < grant_log.size()) chk("t3_grant_order", grant_log[g0 + i], order[i]);
        end
        wait_rsp(r0 + 5, 1'b0);
        chk("t3_quotient", last_q, 1);
        chk("t3_remainder", last_r, 0);

        // 4: response backpressure with a competing request
        bus.rsp_ready = 1'b0;
        r0 = rsp_total;
        send(1, 9, 2, 1'b0);
        set_ops(3, 5, 5);
        bus.req_valid = bus.req_valid | 4'b1000;
        c3 = acc_cnt[3];
        t = 0;
        while (!bus.rsp_valid && t < 50) begin
            tick(1'b0);
            t++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("t4_rsp_valid_held", int'(bus.rsp_valid), 1);
            chk("t4_quotient_held", int'(bus.rsp_quotient), 4);
            chk("t4_remainder_held", int'(bus.rsp_remainder), 1);
            chk("t4_req3_blocked", int'(bus.req_ready[3]), 0);
            tick(1'b0);
        end
        bus.rsp_ready = 1'b1;
        t = 0;
        while (acc_cnt[3] == c3 && t < 50) begin
            tick(1'b0);
            t++;
        end
        chk("t4_req3_accepted", acc_cnt[3] - c3, 1);
        bus.req_valid = '0;
        wait_rsp(r0 + 2, 1'b0);

        // 5: reset mid-division discards the op and rewinds the pointer
        send(0, 14, 5, 1'b0);
        tick(1'b0);
        tick(1'b0);
        reset_n = 1'b0;
        tick(1'b0);
        chk("t5_rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("t5_rst_busy", int'(bus.busy), 0);
        tick(1'b0);
        reset_n = 1'b1;
        tick(1'b0);
        r0 = rsp_total;
        g0 = grant_log.size();
        set_ops(0, 6, 4);
        set_ops(2, 6, 4);
        bus.req_valid = 4'b0101;
        t = 0;
        while (grant_log.size() < g0 + 2 && t < 100) begin
            tick(1'b0);
            t++;
        end
        bus.req_valid = '0;
        chk("t5_accepts", grant_log.size() - g0, 2);
        if (grant_log.size() >= g0 + 2) begin
            chk("t5_first_grant", grant_log[g0], 0);
            chk("t5_second_grant", grant_log[g0 + 1], 2);
        end
        wait_rsp(r0 + 2, 1'b0);
        chk("t5_quotient", last_q, 1);
        chk("t5_remainder", last_r, 2);

        // 6: every operand pair, random requester, random rsp_ready
        a0 = acc_total;
        r0 = rsp_total;
        for (int p = 0; p < 256; p++) send(int'($urandom_range(0, NREQ - 1)), p >> 4, p & 15, 1'b1);
        wait_rsp(r0 + 256, 1'b1);
        chk("t6_accepts", acc_total - a0, 256);
        chk("t6_responses", rsp_total - r0, 256);
        chk("t6_nothing_outstanding", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
